// File: rtl/operand_fetch_unit_pkg.sv
// Shared definitions for the operand fetch unit: FSM state encoding and
// default sizing of the A/B register read buses.
package operand_fetch_unit_pkg;

  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_IDX_W    = 4;
  localparam int DEFAULT_DATA_W   = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/operand_fetch_unit_if.sv
// Request, register-bus and operand signals of the operand fetch unit.
// The master side is the fetch unit; the slave side is its environment.
interface operand_fetch_unit_if
  import operand_fetch_unit_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int IDX_W    = DEFAULT_IDX_W,
  parameter int DATA_W   = DEFAULT_DATA_W
);

  logic                req_valid;
  logic                req_ready;
  logic [IDX_W-1:0]    req_idx_a;
  logic [IDX_W-1:0]    req_idx_b;
  logic [NUM_REGS-1:0] cs_a;
  logic [NUM_REGS-1:0] cs_b;
  logic [DATA_W-1:0]   bus_a;
  logic [DATA_W-1:0]   bus_b;
  logic [DATA_W-1:0]   op_a;
  logic [DATA_W-1:0]   op_b;
  logic                op_valid;
  logic                op_ready;
  logic                op_err;

  modport master (
    input  req_valid, req_idx_a, req_idx_b, bus_a, bus_b, op_ready,
    output req_ready, cs_a, cs_b, op_a, op_b, op_valid, op_err
  );

  modport slave (
    output req_valid, req_idx_a, req_idx_b, bus_a, bus_b, op_ready,
    input  req_ready, cs_a, cs_b, op_a, op_b, op_valid, op_err
  );

endinterface

// File: rtl/operand_fetch_unit_onehot_decoder.sv
// Turns a register index into one-hot chip-select lines, suppressing the
// hard-wired zero register and flagging indices beyond the register bank.
module onehot_decoder
  import operand_fetch_unit_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int IDX_W    = DEFAULT_IDX_W,
  parameter int ZERO_REG = 1
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot,
  output logic                out_of_range
);

  logic selectable;

  always_comb begin
    out_of_range = ({{(32-IDX_W){1'b0}}, idx} >= NUM_REGS);
    selectable   = en && !out_of_range && !((ZERO_REG != 0) && (idx == '0));
    onehot       = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      onehot[i] = selectable && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/operand_fetch_unit.sv
// Read-side master for the dual-read-port register bank: selects the two
// requested registers for one cycle and hands the sampled operands onward.
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int IDX_W    = DEFAULT_IDX_W,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ZERO_REG = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  operand_fetch_unit_if.master ofu
);

  fetch_state_t        state;
  logic                req_ready;
  logic                accept;
  logic [NUM_REGS-1:0] dec_a;
  logic [NUM_REGS-1:0] dec_b;
  logic                oor_a;
  logic                oor_b;
  logic [NUM_REGS-1:0] cs_a_q;
  logic [NUM_REGS-1:0] cs_b_q;
  logic                err_pend;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic                op_valid_q;
  logic                op_err_q;

  assign req_ready = (state == IDLE) || ((state == HOLD) && ofu.op_ready);
  assign accept    = ofu.req_valid && req_ready;

  // Decoding happens on the accepting edge so cs comes straight from flops.
  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ZERO_REG(ZERO_REG)) u_dec_a (
    .idx          (ofu.req_idx_a),
    .en           (accept),
    .onehot       (dec_a),
    .out_of_range (oor_a)
  );

  onehot_decoder #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .ZERO_REG(ZERO_REG)) u_dec_b (
    .idx          (ofu.req_idx_b),
    .en           (accept),
    .onehot       (dec_b),
    .out_of_range (oor_b)
  );

  // A suppressed select leaves the bus floating, so its operand reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cs_a_q     <= '0;
      cs_b_q     <= '0;
      err_pend   <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_valid_q <= 1'b0;
      op_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ofu.req_valid) begin
            cs_a_q   <= dec_a;
            cs_b_q   <= dec_b;
            err_pend <= oor_a || oor_b;
            state    <= SELECT;
          end
        end
        SELECT: begin
          op_a_q     <= (|cs_a_q) ? ofu.bus_a : '0;
          op_b_q     <= (|cs_b_q) ? ofu.bus_b : '0;
          op_err_q   <= err_pend;
          op_valid_q <= 1'b1;
          cs_a_q     <= '0;
          cs_b_q     <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          if (ofu.op_ready) begin
            op_valid_q <= 1'b0;
            if (ofu.req_valid) begin
              cs_a_q   <= dec_a;
              cs_b_q   <= dec_b;
              err_pend <= oor_a || oor_b;
              state    <= SELECT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          cs_a_q     <= '0;
          cs_b_q     <= '0;
          op_valid_q <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign ofu.req_ready = req_ready;
  assign ofu.cs_a      = cs_a_q;
  assign ofu.cs_b      = cs_b_q;
  assign ofu.op_a      = op_a_q;
  assign ofu.op_b      = op_b_q;
  assign ofu.op_valid  = op_valid_q;
  assign ofu.op_err    = op_err_q;

endmodule

// File: tb/tb_operand_fetch_unit.sv
// Randomized bench for operand_fetch_unit with a behavioural register bank
// that writes on falling edges and drives the shared A/B buses.
module tb_operand_fetch_unit;

  localparam int NUM_REGS = 12;
  localparam int IDX_W    = 4;
  localparam int DATA_W   = 32;
  localparam int ZERO_REG = 1;

  logic clk;
  logic rst_n;

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [DATA_W-1:0] float_val;

  int tests_run;
  int tests_failed;

  operand_fetch_unit_if #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DATA_W(DATA_W)) ofu ();

  operand_fetch_unit #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W),
    .DATA_W   (DATA_W),
    .ZERO_REG (ZERO_REG)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ofu   (ofu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The register bank drives a bus only when its chip-select is high.
  always_comb begin
    ofu.bus_a = float_val;
    ofu.bus_b = ~float_val;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ofu.cs_a[i]) ofu.bus_a = regs[i];
      if (ofu.cs_b[i]) ofu.bus_b = regs[i];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic bit suppressed(input logic [IDX_W-1:0] idx);
    return (int'(idx) >= NUM_REGS) || ((ZERO_REG != 0) && (idx == 0));
  endfunction

  function automatic logic [31:0] exp_cs(input logic [IDX_W-1:0] idx);
    return suppressed(idx) ? 32'd0 : (32'd1 << idx);
  endfunction

  function automatic logic [31:0] ref_read(input logic [IDX_W-1:0] idx);
    return suppressed(idx) ? 32'd0 : regs[idx];
  endfunction

  function automatic logic [31:0] exp_err(input logic [IDX_W-1:0] ia, input logic [IDX_W-1:0] ib);
    return ((int'(ia) >= NUM_REGS) || (int'(ib) >= NUM_REGS)) ? 32'd1 : 32'd0;
  endfunction

  task automatic write_reg_at_negedge(input int idx, input logic [31:0] val);
    @(negedge clk);
    regs[idx] = val;
  endtask

  // One full request from IDLE: select, optional write in the select cycle,
  // a backpressured hold with bank writes, then consumption back to IDLE.
  task automatic applyStimulus(input logic [IDX_W-1:0] ia, input logic [IDX_W-1:0] ib,
                               input int hold_cycles, input bit raw_en,
                               input int raw_idx, input logic [31:0] raw_val);
    logic [31:0] ea, eb, ee;
    float_val = $urandom() | 32'h1;
    checkOutput("req_ready_idle", 32'(ofu.req_ready), 32'd1);
    ofu.req_valid = 1'b1;
    ofu.req_idx_a = ia;
    ofu.req_idx_b = ib;
    ofu.op_ready  = 1'b0;
    @(posedge clk); #1;
    ofu.req_valid = 1'b0;
    checkOutput("cs_a_select", 32'(ofu.cs_a), exp_cs(ia));
    checkOutput("cs_b_select", 32'(ofu.cs_b), exp_cs(ib));
    checkOutput("req_ready_select", 32'(ofu.req_ready), 32'd0);
    if (raw_en) write_reg_at_negedge(raw_idx, raw_val);
    @(posedge clk); #1;
    ea = ref_read(ia);
    eb = ref_read(ib);
    ee = exp_err(ia, ib);
    checkOutput("op_valid_hold", 32'(ofu.op_valid), 32'd1);
    checkOutput("op_a", ofu.op_a, ea);
    checkOutput("op_b", ofu.op_b, eb);
    checkOutput("op_err", 32'(ofu.op_err), ee);
    checkOutput("cs_a_hold", 32'(ofu.cs_a), 32'd0);
    for (int c = 0; c < hold_cycles; c++) begin
      ofu.req_valid = 1'(($urandom() & 1));
      ofu.req_idx_a = IDX_W'($urandom_range(1, NUM_REGS - 1));
      write_reg_at_negedge($urandom_range(0, NUM_REGS - 1), $urandom());
      @(posedge clk); #1;
      checkOutput("bp_op_a", ofu.op_a, ea);
      checkOutput("bp_op_b", ofu.op_b, eb);
      checkOutput("bp_op_valid", 32'(ofu.op_valid), 32'd1);
      checkOutput("bp_op_err", 32'(ofu.op_err), ee);
      checkOutput("bp_req_ready", 32'(ofu.req_ready), 32'd0);
      checkOutput("bp_cs", 32'(ofu.cs_a) | 32'(ofu.cs_b), 32'd0);
    end
    ofu.req_valid = 1'b0;
    ofu.op_ready  = 1'b1;
    #1;
    checkOutput("req_ready_consume", 32'(ofu.req_ready), 32'd1);
    @(posedge clk); #1;
    ofu.op_ready = 1'b0;
    checkOutput("op_valid_after", 32'(ofu.op_valid), 32'd0);
    checkOutput("op_a_kept", ofu.op_a, ea);
    checkOutput("cs_idle", 32'(ofu.cs_a) | 32'(ofu.cs_b), 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [IDX_W-1:0] ia, ib;
    logic [IDX_W-1:0] next_a, next_b;
    tests_run     = 0;
    tests_failed  = 0;
    float_val     = 32'hF1F1F1F1;
    ofu.req_valid = 1'b0;
    ofu.req_idx_a = '0;
    ofu.req_idx_b = '0;
    ofu.op_ready  = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) regs[i] = $urandom();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cs_a", 32'(ofu.cs_a), 32'd0);
    checkOutput("rst_op_a", ofu.op_a, 32'd0);
    checkOutput("rst_op_b", ofu.op_b, 32'd0);
    checkOutput("rst_op_valid", 32'(ofu.op_valid), 32'd0);
    checkOutput("rst_op_err", 32'(ofu.op_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_req_ready", 32'(ofu.req_ready), 32'd1);

    // Reset arriving in the middle of a select cycle.
    ofu.req_valid = 1'b1;
    ofu.req_idx_a = 4'd2;
    ofu.req_idx_b = 4'd9;
    @(posedge clk); #1;
    ofu.req_valid = 1'b0;
    checkOutput("pre_rst_cs_a", 32'(ofu.cs_a), 32'h004);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_cs_a", 32'(ofu.cs_a), 32'd0);
    checkOutput("async_rst_cs_b", 32'(ofu.cs_b), 32'd0);
    checkOutput("async_rst_op_valid", 32'(ofu.op_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_rst_req_ready", 32'(ofu.req_ready), 32'd1);
    checkOutput("post_rst_op_valid", 32'(ofu.op_valid), 32'd0);

    regs[3] = 32'h000000AA;
    regs[7] = 32'h12345678;
    applyStimulus(4'd3, 4'd7, 0, 1'b0, 0, 32'd0);
    applyStimulus(4'd5, 4'd5, 0, 1'b1, 5, 32'hDEADBEEF);
    checkOutput("raw_value", ofu.op_a, 32'hDEADBEEF);
    applyStimulus(4'd0, 4'd13, 1, 1'b0, 0, 32'd0);
    applyStimulus(4'd11, 4'd12, 0, 1'b0, 0, 32'd0);
    applyStimulus(4'd4, 4'd9, 5, 1'b0, 0, 32'd0);

    for (int n = 0; n < 40; n++) begin
      ia = IDX_W'($urandom_range(0, 15));
      ib = ($urandom_range(0, 3) == 0) ? ia : IDX_W'($urandom_range(0, 15));
      applyStimulus(ia, ib, $urandom_range(0, 3), 1'(($urandom() & 1)),
                    $urandom_range(0, NUM_REGS - 1), $urandom());
    end

    // Back-to-back requests with the consumer always ready.
    ia = IDX_W'($urandom_range(0, 15));
    ib = IDX_W'($urandom_range(0, 15));
    ofu.req_valid = 1'b1;
    ofu.op_ready  = 1'b1;
    ofu.req_idx_a = ia;
    ofu.req_idx_b = ib;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      checkOutput("b2b_cs_a", 32'(ofu.cs_a), exp_cs(ia));
      checkOutput("b2b_cs_b", 32'(ofu.cs_b), exp_cs(ib));
      checkOutput("b2b_valid_sel", 32'(ofu.op_valid), 32'd0);
      next_a = IDX_W'($urandom_range(0, 15));
      next_b = IDX_W'($urandom_range(0, 15));
      ofu.req_idx_a = next_a;
      ofu.req_idx_b = next_b;
      @(posedge clk); #1;
      checkOutput("b2b_valid_hold", 32'(ofu.op_valid), 32'd1);
      checkOutput("b2b_op_a", ofu.op_a, ref_read(ia));
      checkOutput("b2b_op_b", ofu.op_b, ref_read(ib));
      checkOutput("b2b_op_err", 32'(ofu.op_err), exp_err(ia, ib));
      checkOutput("b2b_cs_hold", 32'(ofu.cs_a) | 32'(ofu.cs_b), 32'd0);
      checkOutput("b2b_req_ready", 32'(ofu.req_ready), 32'd1);
      regs[$urandom_range(0, NUM_REGS - 1)] = $urandom();
      ia = next_a;
      ib = next_b;
    end
    ofu.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("b2b_drain_valid", 32'(ofu.op_valid), 32'd0);
    checkOutput("b2b_drain_ready", 32'(ofu.req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
